if_fetch_ctrl: RTL

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl_pkg.sv | 23 ++
 rtl/pc_next_sel.sv | 24 ++
 rtl/if_fetch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared pipeline types and constants for the fetch stage
package if_fetch_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC select: hold, sequential increment, or word-aligned branch target
import if_fetch_ctrl_pkg::*;

module pc_next_sel (
    input  addr_t   pc,
    input  addr_t   branch_target,
    input  pc_sel_t sel,
    output addr_t   pc_plus4,
    output addr_t   pc_next
);

    // Increment wraps naturally modulo 2^32.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:    pc_next = pc_plus4;
            PC_BRANCH: pc_next = branch_target & 32'hFFFF_FFFC;
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller feeding the IF/ID latch
import if_fetch_ctrl_pkg::*;

module if_fetch_ctrl #(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              ifid_valid,
    output logic [XLEN-1:0]   ifid_instr,
    output logic [ADDR_W-1:0] ifid_npc
);

    fetch_state_t state, state_d;
    pc_sel_t      pc_sel;
    addr_t        pc, pc_next, pc_plus4, req_addr, addr_d;
    word_t        buf_instr;
    logic         ld_mem, ld_buf, ifid_clr, buf_ld;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .branch_target (branch_target),
        .sel           (pc_sel),
        .pc_plus4      (pc_plus4),
        .pc_next       (pc_next)
    );

    assign imem_req  = !rst && (state != ST_HOLD);
    assign imem_addr = req_addr;

    always_comb begin
        state_d  = state;
        pc_sel   = PC_HOLD;
        addr_d   = req_addr;
        ld_mem   = 1'b0;
        ld_buf   = 1'b0;
        ifid_clr = 1'b0;
        buf_ld   = 1'b0;
        if (pcsrc) begin
            pc_sel   = PC_BRANCH;
            ifid_clr = 1'b1;
            // A request still in flight must be drained before the new pc is issued.
            if (state != ST_HOLD && !imem_ready) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_FETCH;
                addr_d  = pc_next;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            buf_ld  = 1'b1;
                            state_d = ST_HOLD;
                        end else begin
                            ld_mem = 1'b1;
                            pc_sel = PC_INC;
                            addr_d = pc_next;
                        end
                    end else if (!stall) begin
                        ifid_clr = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (!stall) ifid_clr = 1'b1;
                    if (imem_ready) begin
                        state_d = ST_FETCH;
                        addr_d  = pc;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ld_buf  = 1'b1;
                        pc_sel  = PC_INC;
                        addr_d  = pc_next;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            buf_instr  <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_npc   <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_next;
            req_addr <= addr_d;
            if (pcsrc)       buf_instr <= '0;
            else if (buf_ld) buf_instr <= imem_rdata;
            if (ifid_clr) begin
                ifid_valid <= 1'b0;
            end else if (ld_mem || ld_buf) begin
                ifid_valid <= 1'b1;
                ifid_instr <= ld_mem ? imem_rdata : buf_instr;
                ifid_npc   <= pc_plus4;
            end
        end
    end

endmodule
